// File: rtl/seq_multiplier_if.sv
// Start/Busy/Done handshake bundle for seq_multiplier.
// master: Start, Signed, A, B, Cancel out; Busy, Done, Hi, Lo in.
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Signed;
    logic             Cancel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Signed, A, B, Cancel,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Signed, A, B, Cancel,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one partial product per clock, signed/unsigned.
// Ports: Clk, Reset_n (async active-low), bus (slave: Start/Signed/A/B/Cancel in,
// Busy/Done/Hi/Lo out). Latency WIDTH+1 clocks from the Start edge.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    seq_multiplier_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] product;

    // -2^(WIDTH-1) negates to itself, which read unsigned is its magnitude.
    assign a_mag = (bus.Signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_mag = (bus.Signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Carry of the upper-half add shifts back in as the new MSB.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_step = {sum, acc[WIDTH-1:1]};
    assign product  = neg ? -acc : acc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (bus.Cancel) begin
                    state_nx = IDLE;
                end else if (cnt == LAST) begin
                    state_nx = SIGN;
                end
            end
            SIGN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        mcand <= a_mag;
                        acc   <= {{WIDTH{1'b0}}, b_mag};
                        cnt   <= '0;
                        neg   <= bus.Signed
                               & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    end
                end
                CALC: begin
                    if (!bus.Cancel) begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                    end
                end
                SIGN: begin
                    if (!bus.Cancel) begin
                        hi_q   <= product[2*WIDTH-1:WIDTH];
                        lo_q   <= product[WIDTH-1:0];
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=32 and WIDTH=8.
// Drives on the falling edge or #1 after the rising edge, samples #1 after it.
module tb_seq_multiplier;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_multiplier_if #(.WIDTH(32)) i32 ();
    seq_multiplier_if #(.WIDTH(8))  i8 ();

    seq_multiplier #(.WIDTH(32)) u32 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (i32)
    );

    seq_multiplier #(.WIDTH(8)) u8 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (i8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run32(input string tag, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        int   lat;
        logic busy_last;
        @(negedge clk);
        i32.Start  = 1'b1;
        i32.Signed = sg;
        i32.A      = a;
        i32.B      = b;
        @(posedge clk);
        #1;
        i32.Start = 1'b0;
        chk({tag, "_busy0"}, 64'(i32.Busy), 64'd1);
        lat       = 0;
        busy_last = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 32) busy_last = i32.Busy;
            if (i32.Done) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'd33);
        chk({tag, "_busy32"}, 64'(busy_last), 64'd1);
        chk({tag, "_busyend"}, 64'(i32.Busy), 64'd0);
        chk({tag, "_hi"}, 64'(i32.Hi), 64'(eh));
        chk({tag, "_lo"}, 64'(i32.Lo), 64'(el));
        @(posedge clk);
        #1;
        chk({tag, "_donepulse"}, 64'(i32.Done), 64'd0);
    endtask

    task automatic run8(input string tag, input logic sg,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eh, input logic [7:0] el);
        int lat;
        @(negedge clk);
        i8.Start  = 1'b1;
        i8.Signed = sg;
        i8.A      = a;
        i8.B      = b;
        @(posedge clk);
        #1;
        i8.Start = 1'b0;
        lat      = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (i8.Done) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'd9);
        chk({tag, "_hi"}, 64'(i8.Hi), 64'(eh));
        chk({tag, "_lo"}, 64'(i8.Lo), 64'(el));
    endtask

    initial begin
        int ndone;
        int second_at;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        i32.Start  = 1'b0;
        i32.Signed = 1'b0;
        i32.A      = '0;
        i32.B      = '0;
        i32.Cancel = 1'b0;
        i8.Start   = 1'b0;
        i8.Signed  = 1'b0;
        i8.A       = '0;
        i8.B       = '0;
        i8.Cancel  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(i32.Busy), 64'd0);
        chk("rst_done", 64'(i32.Done), 64'd0);
        chk("rst_hi", 64'(i32.Hi), 64'd0);
        chk("rst_lo", 64'(i32.Lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run32("u_ffxff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001);
        run32("s_m1xm1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h00000000, 32'h00000001);
        run32("s_m3x5", 1'b1, 32'hFFFFFFFD, 32'd5,
              32'hFFFFFFFF, 32'hFFFFFFF1);
        run32("s_minxmin", 1'b1, 32'h80000000, 32'h80000000,
              32'h40000000, 32'h00000000);
        run32("s_zero", 1'b1, 32'h00000000, 32'hFFFFFFF0,
              32'h00000000, 32'h00000000);

        run8("w8_minxmin", 1'b1, 8'h80, 8'h80, 8'h40, 8'h00);
        run8("w8_7fx80", 1'b1, 8'h7F, 8'h80, 8'hC0, 8'h80);
        run8("w8_u_ffxff", 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01);

        // Start held high from edge 0 through edge 34.
        @(negedge clk);
        i32.Start  = 1'b1;
        i32.Signed = 1'b0;
        i32.A      = 32'd7;
        i32.B      = 32'd6;
        @(posedge clk);
        #1;
        ndone     = 0;
        second_at = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (i32.Done) begin
                ndone++;
                if (ndone == 2) second_at = n;
            end
            if (n == 34) i32.Start = 1'b0;
        end
        chk("b2b_ndone", 64'(ndone), 64'd2);
        chk("b2b_second", 64'(second_at), 64'd67);
        chk("b2b_hi", 64'(i32.Hi), 64'd0);
        chk("b2b_lo", 64'(i32.Lo), 64'd42);

        // Cancel sampled at the 10th CALC edge.
        @(negedge clk);
        i32.Start = 1'b1;
        i32.A     = 32'd3;
        i32.B     = 32'd4;
        @(posedge clk);
        #1;
        i32.Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("cxl_busy_pre", 64'(i32.Busy), 64'd1);
        i32.Cancel = 1'b1;
        @(posedge clk);
        #1;
        i32.Cancel = 1'b0;
        chk("cxl_busy", 64'(i32.Busy), 64'd0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (i32.Done) ndone++;
        end
        chk("cxl_nodone", 64'(ndone), 64'd0);
        chk("cxl_hi", 64'(i32.Hi), 64'd0);
        chk("cxl_lo", 64'(i32.Lo), 64'd42);
        run32("cxl_after", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);

        // Asynchronous reset between edges mid-CALC.
        @(negedge clk);
        i32.Start = 1'b1;
        i32.A     = 32'd5;
        i32.B     = 32'd5;
        @(posedge clk);
        #1;
        i32.Start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(i32.Busy), 64'd0);
        chk("arst_done", 64'(i32.Done), 64'd0);
        chk("arst_hi", 64'(i32.Hi), 64'd0);
        chk("arst_lo", 64'(i32.Lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (i32.Done) ndone++;
        end
        chk("arst_nodone", 64'(ndone), 64'd0);
        run32("arst_after", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
